fp_add_arbiter: RTL and testbench
=================================

Name: fp_add_arbiter

Overview:
- Shares one fixed-latency, non-stallable fp_add pipeline between NUM_REQ requesters.
- Each requester has a valid/ready operand port and a valid/ready result port.
- Arbitration is round-robin; a tag pipeline routes each sum back to its issuing requester.
- Per-requester credits plus a result FIFO guarantee no result is dropped, because the adder has no backpressure.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADD_LAT, 8: cycles from add_in_vld to add_sum_vld in the attached adder.
- RES_DEPTH, 4: result FIFO depth per requester; also the max outstanding ops per requester.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_vld  in  NUM_REQ  operand request valid, one bit per requester
- req_rdy  out  NUM_REQ  operand accepted this cycle (one-hot or zero)
- req_a  in  32*NUM_REQ  operand A, requester i at [32i+31:32i], IEEE-754 single
- req_b  in  32*NUM_REQ  operand B, same packing
- res_vld  out  NUM_REQ  result FIFO head valid
- res_rdy  in  NUM_REQ  requester pops result
- res_data  out  32*NUM_REQ  result FIFO head, same packing
- add_in_vld  out  1  issue strobe to adder
- add_a  out  32  adder operand A
- add_b  out  32  adder operand B
- add_sum_vld  in  1  adder result valid
- add_sum  in  32  adder result
- err  out  1  sticky protocol error

Behaviour:
- Reset values: req_rdy=0, res_vld=0, add_in_vld=0, add_a=add_b=0, err=0.
- Reset also clears: rr_ptr=0, all credits, FIFOs, tag pipeline.
- Reset mid-operation: in-flight tags are discarded; any add_sum_vld arriving after reset with no matching tag sets err.
  - Integration requires the adder to be reset together with this block.

Credits:
- credit[i] = ops in flight + entries in FIFO i; range 0..RES_DEPTH.
- Requester i is eligible when req_vld[i]=1 and credit[i]<RES_DEPTH.
- credit[i] +1 on grant to i, −1 on pop (res_vld[i]&res_rdy[i]).
- Grant and pop in the same cycle: credit unchanged.

Arbitration:
- Combinational from registered state plus req_vld/res_rdy.
- Search starts at rr_ptr and ascends modulo NUM_REQ; the first eligible requester wins.
- req_rdy[winner]=1 for that cycle only.
- On a grant, rr_ptr <= winner+1 mod NUM_REQ; with no grant, rr_ptr holds.
- Throughput: at most one grant per cycle; back-to-back grants allowed.
- Requesters must hold req_a/req_b stable while req_vld=1 and req_rdy=0.

Issue:
- Registered: in the cycle after a grant, add_in_vld=1 and add_a/add_b = the winner's operands.
- Otherwise add_in_vld=0 and add_a/add_b hold their last value.

Tag pipeline:
- ADD_LAT-deep shift register of {vld, id[$clog2(NUM_REQ)-1:0]}.
- Loaded with {add_in_vld, issuing id} in lockstep with add_in_vld.
- Its output is aligned with add_sum_vld.
- Output tag vld != add_sum_vld in any cycle: set err, drop the sum.

Result write:
- When add_sum_vld and tag vld are both 1, add_sum is written to FIFO[tag id] on that clock edge.
- Write to a full FIFO is unreachable under credits; if it occurs, set err and drop the data.

Result FIFO:
- Show-ahead: res_data[i] is the head.
- res_vld[i]=1 while not empty; it is registered, so first visibility is the cycle after the write.
- Simultaneous write and pop allowed in any state; occupancy unchanged.
- Pointers wrap modulo RES_DEPTH.

Latency:
- Handshake at cycle T → add_in_vld at T+1 → add_sum_vld at T+1+ADD_LAT → res_vld at T+2+ADD_LAT.
- With defaults: T+10.

err: sticky until rst.

Test Plan:
- Single op, requester 0, a=0x3F800000, b=0x40000000, handshake at cycle T:
  - add_in_vld at T+1 with add_a=0x3F800000, add_b=0x40000000.
  - res_vld[0] at T+10, res_data[0]=0x40400000; other res_vld stay 0.
- All four req_vld high for 8 cycles, res_rdy=all 1, rr_ptr=0:
  - Grants 0,1,2,3,0,1,2,3 on consecutive cycles.
  - Each requester receives its own sums, in order.
- Requester 2 holds res_rdy[2]=0 and issues 6 ops:
  - First 4 accepted; req_rdy[2] stays 0 afterwards while other requesters keep being granted.
  - One pop re-enables exactly one grant to requester 2.
- Requester 1 at credit=RES_DEPTH, pop and new req_vld in the same cycle:
  - No grant that cycle, since eligibility uses registered credit.
  - Next cycle grant; credit stays 4; no err.
- Reset asserted 3 cycles after an issue:
  - All outputs at reset values the next cycle.
  - Adder reset with the block: no res_vld, err=0.
  - Adder not reset, so add_sum_vld still arrives: err=1.
- Inject add_sum_vld=1 with no prior issue: err=1 and stays 1; no FIFO written.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
//
// Shares one fixed-latency, non-stallable floating-point adder between
// NUM_REQ requesters. Requests are granted round-robin and each grant is
// registered into the adder one cycle later. A tag shift register tracks
// which requester issued each operation, so every sum is written back into
// that requester's show-ahead result FIFO.
//
// The adder cannot be stalled, so a requester may only be granted while
// its credit count (ops in flight plus results waiting in its FIFO) is
// below RES_DEPTH. That guarantees a FIFO slot exists for every sum that
// comes back.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_vld       per-requester operand valid
//   req_rdy       per-requester operand accept (one-hot or zero)
//   req_a, req_b  packed operands, requester i at [32i+31:32i]
//   res_vld       per-requester result FIFO not empty
//   res_rdy       per-requester result pop
//   res_data      packed result FIFO heads, requester i at [32i+31:32i]
//   add_in_vld    issue strobe to the adder
//   add_a, add_b  adder operands
//   add_sum_vld   adder result valid, ADD_LAT cycles after add_in_vld
//   add_sum       adder result
//   err           sticky protocol error (tag/result misalignment or
//                 write into a full FIFO)

module fp_add_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADD_LAT   = 8,
  parameter int RES_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_vld,
  output logic [NUM_REQ-1:0]     req_rdy,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     res_vld,
  input  logic [NUM_REQ-1:0]     res_rdy,
  output logic [32*NUM_REQ-1:0]  res_data,
  output logic                   add_in_vld,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  input  logic                   add_sum_vld,
  input  logic [31:0]            add_sum,
  output logic                   err
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CNT_W = $clog2(RES_DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RES_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RES_DEPTH - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  // Arbitration state
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] credit_q [NUM_REQ];
  logic [CNT_W-1:0] credit_d [NUM_REQ];

  // Issue registers feeding the adder
  logic             add_in_vld_q, add_in_vld_d;
  logic [31:0]      add_a_q, add_a_d;
  logic [31:0]      add_b_q, add_b_d;
  logic [ID_W-1:0]  issue_id_q, issue_id_d;

  // Tag pipeline, aligned with the adder latency
  logic [ADD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]    tag_id_q [ADD_LAT];
  logic [ID_W-1:0]    tag_id_d [ADD_LAT];

  // Result FIFOs
  logic [31:0]      mem_q [NUM_REQ][RES_DEPTH];
  logic [31:0]      mem_d [NUM_REQ][RES_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_REQ];
  logic [PTR_W-1:0] wr_ptr_d [NUM_REQ];
  logic [PTR_W-1:0] rd_ptr_q [NUM_REQ];
  logic [PTR_W-1:0] rd_ptr_d [NUM_REQ];
  logic [CNT_W-1:0] count_q [NUM_REQ];
  logic [CNT_W-1:0] count_d [NUM_REQ];

  logic err_q, err_d;

  // Combinational helpers
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] wr_hit;
  logic [NUM_REQ-1:0] wr_ok;
  logic [NUM_REQ-1:0] wr_overflow;
  logic               grant_found;
  logic               grant;
  logic [ID_W-1:0]    grant_id;
  logic               tag_out_vld;
  logic [ID_W-1:0]    tag_out_id;
  logic               wr_en;
  int                 search_idx;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  // FIFO status, head data and pops are decoded straight from registered
  // state so res_vld only rises the cycle after the write lands.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo_out
    assign res_vld[g]            = (count_q[g] != '0);
    assign res_data[32*g +: 32]  = mem_q[g][rd_ptr_q[g]];
    assign pop[g]                = res_vld[g] & res_rdy[g];
  end

  assign add_in_vld  = add_in_vld_q;
  assign add_a       = add_a_q;
  assign add_b       = add_b_q;
  assign err         = err_q;
  assign tag_out_vld = tag_vld_q[ADD_LAT-1];
  assign tag_out_id  = tag_id_q[ADD_LAT-1];
  assign wr_en       = add_sum_vld & tag_out_vld;

  // A requester is eligible only on registered credit, so a pop in the
  // same cycle does not free a slot until the following cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_vld[i] && (credit_q[i] < DEPTH_CNT);
    end
  end

  // Round-robin search starting at rr_ptr; the first eligible requester
  // in ascending (wrapping) order wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    search_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      search_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found && eligible[search_idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(search_idx);
      end
    end
  end

  // Grants are suppressed while reset is held so no requester sees a
  // handshake that the reset would then throw away.
  always_comb begin
    grant   = grant_found & ~rst;
    req_rdy = '0;
    if (grant) begin
      req_rdy[grant_id] = 1'b1;
    end
  end

  // Pointer advances past the winner; it holds when nobody is granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
    end
  end

  // The winner's operands are registered into the adder the cycle after
  // the grant; the operand registers hold between issues.
  always_comb begin
    add_in_vld_d = grant;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    issue_id_d   = issue_id_q;
    if (grant) begin
      add_a_d    = req_a[32*int'(grant_id) +: 32];
      add_b_d    = req_b[32*int'(grant_id) +: 32];
      issue_id_d = grant_id;
    end
  end

  // Tag shift register loaded in lockstep with add_in_vld, so its last
  // stage lines up with add_sum_vld.
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_vld_d[0] = add_in_vld_q;
    for (int k = 0; k < ADD_LAT; k++) begin
      tag_id_d[k] = tag_id_q[k];
    end
    tag_id_d[0] = issue_id_q;
    for (int k = 1; k < ADD_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  // Route the returning sum to its FIFO. A full FIFO only accepts the
  // write if it is being popped in the same cycle; otherwise the sum is
  // dropped and flagged.
  always_comb begin
    wr_hit      = '0;
    wr_ok       = '0;
    wr_overflow = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_hit[i]      = wr_en && (tag_out_id == ID_W'(i));
      wr_ok[i]       = wr_hit[i] && ((count_q[i] != DEPTH_CNT) || pop[i]);
      wr_overflow[i] = wr_hit[i] && (count_q[i] == DEPTH_CNT) && !pop[i];
    end
  end

  // FIFO pointers, occupancy and storage.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < RES_DEPTH; j++) begin
        mem_d[i][j] = mem_q[i][j];
      end
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (wr_ok[i]) begin
        mem_d[i][wr_ptr_q[i]] = add_sum;
        wr_ptr_d[i]           = next_ptr(wr_ptr_q[i]);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = next_ptr(rd_ptr_q[i]);
      end
      if (wr_ok[i] && !pop[i]) begin
        count_d[i] = count_q[i] + CNT_W'(1);
      end else if (!wr_ok[i] && pop[i]) begin
        count_d[i] = count_q[i] - CNT_W'(1);
      end
    end
  end

  // Credits count from grant until pop, covering both the time in the
  // adder and the time waiting in the FIFO.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      credit_d[i] = credit_q[i];
      if (grant && (grant_id == ID_W'(i)) && !pop[i]) begin
        credit_d[i] = credit_q[i] + CNT_W'(1);
      end else if (!(grant && (grant_id == ID_W'(i))) && pop[i]) begin
        credit_d[i] = credit_q[i] - CNT_W'(1);
      end
    end
  end

  // Sticky error: any sum without a matching tag (or tag without sum),
  // or a write that found its FIFO full.
  always_comb begin
    err_d = err_q;
    if ((add_sum_vld != tag_out_vld) || (wr_overflow != '0)) begin
      err_d = 1'b1;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      add_in_vld_q <= 1'b0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      issue_id_q   <= '0;
      tag_vld_q    <= '0;
      err_q        <= 1'b0;
      for (int k = 0; k < ADD_LAT; k++) begin
        tag_id_q[k] <= '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        credit_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      add_in_vld_q <= add_in_vld_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      issue_id_q   <= issue_id_d;
      tag_vld_q    <= tag_vld_d;
      err_q        <= err_d;
      for (int k = 0; k < ADD_LAT; k++) begin
        tag_id_q[k] <= tag_id_d[k];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        credit_q[i] <= credit_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  // FIFO storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < RES_DEPTH; j++) begin
        mem_q[i][j] <= mem_d[i][j];
      end
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter
//
// Drives fp_add_arbiter with directed scenarios and randomized traffic.
// Includes a behavioural fixed-latency adder (optionally reset with the
// block) and a reference model of grant order, credits and per-requester
// result ordering.

module tb_fp_add_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ADD_LAT   = 8;
  localparam int RES_DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_vld = '0;
  logic [NUM_REQ-1:0]    req_rdy;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    res_vld;
  logic [NUM_REQ-1:0]    res_rdy = '0;
  logic [32*NUM_REQ-1:0] res_data;
  logic                  add_in_vld;
  logic [31:0]           add_a;
  logic [31:0]           add_b;
  logic                  add_sum_vld;
  logic [31:0]           add_sum;
  logic                  err;

  logic [31:0] op_a [NUM_REQ];
  logic [31:0] op_b [NUM_REQ];

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural adder
  logic [ADD_LAT-1:0] pipe_vld = '0;
  logic [31:0]        pipe_sum [ADD_LAT];
  logic               adder_follows_rst = 1'b1;
  logic               inject_vld = 1'b0;
  logic [31:0]        inject_data = '0;

  // Reference model state (written only by the monitor)
  logic [31:0] exp_q [NUM_REQ][$];
  logic [31:0] got_q [NUM_REQ][$];
  int          m_cnt [NUM_REQ];
  int          m_ptr = 0;
  int          hs_count [NUM_REQ];
  int          hs_seen [NUM_REQ];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_a[32*g +: 32] = op_a[g];
    assign req_b[32*g +: 32] = op_b[g];
  end

  fp_add_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ADD_LAT  (ADD_LAT),
    .RES_DEPTH(RES_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_a      (req_a),
    .req_b      (req_b),
    .res_vld    (res_vld),
    .res_rdy    (res_rdy),
    .res_data   (res_data),
    .add_in_vld (add_in_vld),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum_vld(add_sum_vld),
    .add_sum    (add_sum),
    .err        (err)
  );

  function automatic real sp2real(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) return 0.0;
    d[63]    = s[31];
    d[62:52] = {3'b000, s[30:23]} + 11'd896;
    d[51:0]  = {s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return real2sp(sp2real(a) + sp2real(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    int v;
    v = int'($urandom_range(2000)) - 1000;
    return real2sp(real'(v));
  endfunction

  // Expected round-robin winner given current requests and model credits.
  function automatic int exp_winner();
    int idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_ptr + k) % NUM_REQ;
      if (req_vld[idx] && (m_cnt[idx] < RES_DEPTH)) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int w);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst && adder_follows_rst) begin
      pipe_vld <= '0;
    end else begin
      for (int k = ADD_LAT-1; k > 0; k--) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_sum[k] <= pipe_sum[k-1];
      end
      pipe_vld[0] <= add_in_vld;
      pipe_sum[0] <= add_in_vld ? fadd(add_a, add_b) : 32'd0;
    end
  end

  assign add_sum_vld = pipe_vld[ADD_LAT-1] | inject_vld;
  assign add_sum     = inject_vld ? inject_data : pipe_sum[ADD_LAT-1];

  // Monitor: records handshakes and pops into the reference model.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        exp_q[i].delete();
        got_q[i].delete();
        m_cnt[i] = 0;
      end
      m_ptr = 0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          exp_q[i].push_back(fadd(op_a[i], op_b[i]));
          m_cnt[i]++;
          m_ptr = (i + 1) % NUM_REQ;
          hs_count[i]++;
        end
        if (res_vld[i] && res_rdy[i]) begin
          got_q[i].push_back(res_data[32*i +: 32]);
          m_cnt[i]--;
        end
      end
    end
  end

  // Advance one cycle; give a requester new operands only once its
  // previous request was accepted or withdrawn.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_vld[i] || (hs_count[i] != hs_seen[i])) begin
        op_a[i] = rand_fp();
        op_b[i] = rand_fp();
      end
      hs_seen[i] = hs_count[i];
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_vld    = '0;
    res_rdy    = '0;
    inject_vld = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    req_vld = '0;
    res_rdy = '1;
    repeat (ADD_LAT + RES_DEPTH + 12) tick();
    res_rdy = '0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    req_vld = '1;
    res_rdy = '0;
    tick();
    @(negedge clk);
    tests_run++;
    if (req_rdy !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rdy_during_reset: got %b expected 0", req_rdy);
    end
    tick();
    rst     = 1'b0;
    req_vld = '0;
    @(negedge clk);
    tests_run++;
    if (req_rdy !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_req_rdy: got %b expected 0", req_rdy);
    end
    tests_run++;
    if (res_vld !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_res_vld: got %b expected 0", res_vld);
    end
    tests_run++;
    if ({add_in_vld, add_a, add_b} !== 65'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_issue: got vld=%b a=%h b=%h expected all 0", add_in_vld, add_a, add_b);
    end
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_err: got %b expected 0", err);
    end
  endtask

  task automatic test_single_op();
    do_reset();
    op_a[0] = 32'h3F800000;
    op_b[0] = 32'h40000000;
    req_vld = 4'b0001;
    @(negedge clk);
    tests_run++;
    if (req_rdy !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL single_grant: got %b expected 0001", req_rdy);
    end
    tick();
    req_vld = '0;
    @(negedge clk);
    tests_run++;
    if ({add_in_vld, add_a, add_b} !== {1'b1, 32'h3F800000, 32'h40000000}) begin
      tests_failed++;
      $display("[TB] FAIL single_issue: got vld=%b a=%h b=%h expected 1 3f800000 40000000", add_in_vld, add_a, add_b);
    end
    repeat (8) tick();
    @(negedge clk);
    tests_run++;
    if (res_vld !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL single_early: got %b at T+9 expected 0000", res_vld);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (res_vld !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL single_res_vld: got %b at T+10 expected 0001", res_vld);
    end
    tests_run++;
    if (res_data[31:0] !== 32'h40400000) begin
      tests_failed++;
      $display("[TB] FAIL single_res_data: got %h expected 40400000", res_data[31:0]);
    end
    res_rdy = 4'b0001;
    tick();
    res_rdy = '0;
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] expv;
    do_reset();
    res_rdy = '1;
    req_vld = '1;
    for (int c = 0; c < 8; c++) begin
      expv = onehot(c % NUM_REQ);
      @(negedge clk);
      tests_run++;
      if (req_rdy !== expv) begin
        tests_failed++;
        $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", c, req_rdy, expv);
      end
      tick();
    end
    drain();
    for (int i = 0; i < NUM_REQ; i++) begin
      tests_run++;
      if (got_q[i].size() != 2) begin
        tests_failed++;
        $display("[TB] FAIL rr_count[%0d]: got %0d results expected 2", i, got_q[i].size());
      end
      for (int j = 0; j < got_q[i].size() && j < exp_q[i].size(); j++) begin
        tests_run++;
        if (got_q[i][j] !== exp_q[i][j]) begin
          tests_failed++;
          $display("[TB] FAIL rr_data[%0d][%0d]: got %h expected %h", i, j, got_q[i][j], exp_q[i][j]);
        end
      end
    end
  endtask

  task automatic test_credit_limit();
    int n2;
    int others_after;
    logic [NUM_REQ-1:0] expv;
    do_reset();
    res_rdy      = 4'b1011;
    req_vld      = 4'b0111;
    n2           = 0;
    others_after = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      expv = onehot(exp_winner());
      tests_run++;
      if (req_rdy !== expv) begin
        tests_failed++;
        $display("[TB] FAIL credit_grant[%0d]: got %b expected %b", c, req_rdy, expv);
      end
      if (req_rdy[2]) n2++;
      else if (n2 == RES_DEPTH && req_rdy != '0) others_after++;
      tick();
    end
    tests_run++;
    if (n2 != RES_DEPTH) begin
      tests_failed++;
      $display("[TB] FAIL credit_cap: got %0d grants to 2 expected %0d", n2, RES_DEPTH);
    end
    tests_run++;
    if (others_after == 0) begin
      tests_failed++;
      $display("[TB] FAIL credit_others: got %0d later grants to others expected >0", others_after);
    end
    @(negedge clk);
    tests_run++;
    if (res_vld[2] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL credit_fifo_full: got res_vld[2]=%b expected 1", res_vld[2]);
    end
    tick();
    res_rdy[2] = 1'b1;
    tick();
    res_rdy[2] = 1'b0;
    n2 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_rdy[2]) n2++;
      tick();
    end
    tests_run++;
    if (n2 != 1) begin
      tests_failed++;
      $display("[TB] FAIL credit_refill: got %0d grants to 2 after one pop expected 1", n2);
    end
    drain();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (got_q[i].size() != exp_q[i].size()) begin
        tests_failed++;
        $display("[TB] FAIL credit_count[%0d]: got %0d results expected %0d", i, got_q[i].size(), exp_q[i].size());
      end
      for (int j = 0; j < got_q[i].size() && j < exp_q[i].size(); j++) begin
        tests_run++;
        if (got_q[i][j] !== exp_q[i][j]) begin
          tests_failed++;
          $display("[TB] FAIL credit_data[%0d][%0d]: got %h expected %h", i, j, got_q[i][j], exp_q[i][j]);
        end
      end
    end
  endtask

  task automatic test_pop_and_request();
    int n;
    do_reset();
    res_rdy = '0;
    req_vld = 4'b0010;
    n = 0;
    for (int c = 0; c < 20 && n < RES_DEPTH; c++) begin
      @(negedge clk);
      if (req_rdy[1]) n++;
      tick();
    end
    req_vld = '0;
    tests_run++;
    if (n != RES_DEPTH) begin
      tests_failed++;
      $display("[TB] FAIL popreq_fill: got %0d grants expected %0d", n, RES_DEPTH);
    end
    repeat (ADD_LAT + 4) tick();
    res_rdy = 4'b0010;
    req_vld = 4'b0010;
    @(negedge clk);
    tests_run++;
    if (req_rdy !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL popreq_same_cycle: got %b expected 0000", req_rdy);
    end
    tick();
    res_rdy = '0;
    @(negedge clk);
    tests_run++;
    if (req_rdy !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL popreq_next_cycle: got %b expected 0010", req_rdy);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (req_rdy !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL popreq_credit_full: got %b expected 0000", req_rdy);
    end
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL popreq_err: got %b expected 0", err);
    end
    drain();
    tests_run++;
    if (got_q[1].size() != RES_DEPTH + 1) begin
      tests_failed++;
      $display("[TB] FAIL popreq_count: got %0d results expected %0d", got_q[1].size(), RES_DEPTH + 1);
    end
    for (int j = 0; j < got_q[1].size() && j < exp_q[1].size(); j++) begin
      tests_run++;
      if (got_q[1][j] !== exp_q[1][j]) begin
        tests_failed++;
        $display("[TB] FAIL popreq_data[%0d]: got %h expected %h", j, got_q[1][j], exp_q[1][j]);
      end
    end
  endtask

  task automatic test_reset_midop();
    int bad;
    do_reset();
    req_vld = 4'b0001;
    tick();
    req_vld = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({req_rdy, res_vld, add_in_vld, add_a, add_b, err} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: got rdy=%b rv=%b iv=%b a=%h b=%h err=%b expected all 0",
               req_rdy, res_vld, add_in_vld, add_a, add_b, err);
    end
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (res_vld != '0) bad++;
      tick();
    end
    tests_run++;
    if (bad != 0 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_clean: got %0d res_vld cycles err=%b expected 0 and 0", bad, err);
    end
    do_reset();
    adder_follows_rst = 1'b0;
    req_vld = 4'b0001;
    tick();
    req_vld = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 20 && err !== 1'b1; c++) begin
      @(negedge clk);
      if (res_vld != '0) bad++;
      tick();
    end
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_orphan_err: got %b expected 1", err);
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_orphan_write: got %0d res_vld cycles expected 0", bad);
    end
    adder_follows_rst = 1'b1;
  endtask

  task automatic test_inject();
    do_reset();
    inject_vld  = 1'b1;
    inject_data = rand_fp();
    tick();
    inject_vld = 1'b0;
    @(negedge clk);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL inject_err: got %b expected 1", err);
    end
    repeat (10) tick();
    @(negedge clk);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL inject_sticky: got %b expected 1", err);
    end
    tests_run++;
    if (res_vld !== '0) begin
      tests_failed++;
      $display("[TB] FAIL inject_no_write: got %b expected 0000", res_vld);
    end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] expv;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_vld = NUM_REQ'($urandom);
      res_rdy = NUM_REQ'($urandom);
      @(negedge clk);
      expv = onehot(exp_winner());
      tests_run++;
      if (req_rdy !== expv) begin
        tests_failed++;
        $display("[TB] FAIL rand_grant[%0d]: got %b expected %b", c, req_rdy, expv);
      end
      tick();
    end
    drain();
    for (int i = 0; i < NUM_REQ; i++) begin
      tests_run++;
      if (got_q[i].size() != exp_q[i].size()) begin
        tests_failed++;
        $display("[TB] FAIL rand_count[%0d]: got %0d results expected %0d", i, got_q[i].size(), exp_q[i].size());
      end
      for (int j = 0; j < got_q[i].size() && j < exp_q[i].size(); j++) begin
        tests_run++;
        if (got_q[i][j] !== exp_q[i][j]) begin
          tests_failed++;
          $display("[TB] FAIL rand_data[%0d][%0d]: got %h expected %h", i, j, got_q[i][j], exp_q[i][j]);
        end
      end
    end
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rand_err: got %b expected 0", err);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    test_reset();
    test_single_op();
    test_round_robin();
    test_credit_limit();
    test_pop_and_request();
    test_reset_midop();
    test_inject();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
